// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM rectangle-fill engine.
package vram_pkg;

   localparam int ROW_PX_CNT = 640;
   localparam int ROW_CNT    = 480;
   localparam int ADDR_WIDTH = 19;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_t;

endpackage

// File: rtl/vram_row_addr.sv
// Row base address y*640 built from two shifts and an add; no multiplier.
module vram_row_addr
   import vram_pkg::*;
(
   input  logic [9:0]            y_i,
   output logic [ADDR_WIDTH-1:0] base_o
);

   // 640 = 512 + 128
   assign base_o = {y_i, 9'b0} + {2'b00, y_i, 7'b0};

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: writes one byte per pixel in raster order over an Avalon-style master.
// Define VRAM_FILL_CLIP_EN to clip the rectangle against the visible frame.
module vram_rect_fill
   import vram_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [9:0]            i_x0,
   input  logic [9:0]            i_y0,
   input  logic [9:0]            i_width,
   input  logic [9:0]            i_height,
   input  logic [7:0]            i_color,
   output logic [ADDR_WIDTH-1:0] o_vram_address,
   output logic [7:0]            o_vram_writedata,
   output logic                  o_vram_write,
   input  logic                  i_vram_waitrequest,
   output logic                  o_busy,
   output logic                  o_done
);

   fill_state_t           state_q;
   logic                  ready_q;
   logic                  done_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] row_start_q;
   logic [7:0]            color_q;
   logic [9:0]            col_cnt_q;
   logic [9:0]            row_cnt_q;
   logic [9:0]            col_reload_q;

   logic [9:0]            x0_q;
   logic [9:0]            y0_q;
   logic [9:0]            w_q;
   logic [9:0]            h_q;

   logic [9:0]            eff_w_d;
   logic [9:0]            eff_h_d;
   logic [ADDR_WIDTH-1:0] row_base_d;
   logic [ADDR_WIDTH-1:0] start_addr_d;
   logic                  accept;

   assign accept = i_cmd_valid & ready_q;

   // Geometry is only consumed in SETUP, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         x0_q <= i_x0;
         y0_q <= i_y0;
         w_q  <= i_width;
         h_q  <= i_height;
      end
   end

   vram_row_addr u_row_addr (
      .y_i    (y0_q),
      .base_o (row_base_d)
   );

   assign start_addr_d = row_base_d + ADDR_WIDTH'(x0_q);

   always_comb begin
      eff_w_d = w_q;
      eff_h_d = h_q;
`ifdef VRAM_FILL_CLIP_EN
      if (x0_q >= 10'(ROW_PX_CNT))
         eff_w_d = 10'd0;
      else if (w_q > 10'(ROW_PX_CNT) - x0_q)
         eff_w_d = 10'(ROW_PX_CNT) - x0_q;
      if (y0_q >= 10'(ROW_CNT))
         eff_h_d = 10'd0;
      else if (h_q > 10'(ROW_CNT) - y0_q)
         eff_h_d = 10'(ROW_CNT) - y0_q;
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b1;
         done_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         row_start_q  <= '0;
         color_q      <= 8'd0;
         col_cnt_q    <= 10'd0;
         row_cnt_q    <= 10'd0;
         col_reload_q <= 10'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // Ready is also high in DONE, so a new command may be taken there.
               if (accept) begin
                  state_q <= ST_SETUP;
                  ready_q <= 1'b0;
                  color_q <= i_color;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               col_cnt_q    <= eff_w_d - 10'd1;
               row_cnt_q    <= eff_h_d - 10'd1;
               col_reload_q <= eff_w_d - 10'd1;
               row_start_q  <= start_addr_d;
               addr_q       <= start_addr_d;
               if (eff_w_d == 10'd0 || eff_h_d == 10'd0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
               end else begin
                  state_q <= ST_WRITE;
                  write_q <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (!i_vram_waitrequest) begin
                  if (col_cnt_q != 10'd0) begin
                     col_cnt_q <= col_cnt_q - 10'd1;
                     addr_q    <= addr_q + ADDR_WIDTH'(1);
                  end else if (row_cnt_q != 10'd0) begin
                     row_cnt_q   <= row_cnt_q - 10'd1;
                     col_cnt_q   <= col_reload_q;
                     row_start_q <= row_start_q + ADDR_WIDTH'(ROW_PX_CNT);
                     addr_q      <= row_start_q + ADDR_WIDTH'(ROW_PX_CNT);
                  end else begin
                     write_q <= 1'b0;
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_cmd_ready      = ready_q;
   assign o_busy           = ~ready_q;
   assign o_done           = done_q;
   assign o_vram_write     = write_q;
   assign o_vram_address   = addr_q;
   assign o_vram_writedata = color_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill; reference model honours VRAM_FILL_CLIP_EN.
module tb_vram_rect_fill;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  x0, y0, width, height;
   logic [7:0]  color;
   logic [18:0] vaddr;
   logic [7:0]  vdata;
   logic        vwrite;
   logic        waitreq;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int got_q[$];

   always #5 clk = ~clk;

   vram_rect_fill dut (
      .i_clk              (clk),
      .i_reset            (rst),
      .i_cmd_valid        (cmd_valid),
      .o_cmd_ready        (cmd_ready),
      .i_x0               (x0),
      .i_y0               (y0),
      .i_width            (width),
      .i_height           (height),
      .i_color            (color),
      .o_vram_address     (vaddr),
      .o_vram_writedata   (vdata),
      .o_vram_write       (vwrite),
      .i_vram_waitrequest (waitreq),
      .o_busy             (busy),
      .o_done             (done)
   );

   // Raster list of byte addresses the rectangle should cover.
   task automatic build_model(input int mx, input int my, input int mw, input int mh);
      int ew, eh;
      exp_q.delete();
      ew = mw;
      eh = mh;
`ifdef VRAM_FILL_CLIP_EN
      if (mx >= 640) ew = 0; else if (mw > 640 - mx) ew = 640 - mx;
      if (my >= 480) eh = 0; else if (mh > 480 - my) eh = 480 - my;
`endif
      for (int r = 0; r < eh; r++)
         for (int c = 0; c < ew; c++)
            exp_q.push_back(((my + r) * 640 + mx + c) % 524288);
   endtask

   // Issue one command and follow it to completion, checking every cycle.
   task automatic run_cmd(input string name, input int cx, input int cy, input int cw, input int ch,
                          input logic [7:0] cc, input int stall_pct, input int stall_idx,
                          input int stall_len, input bit spam);
      int          done_j = -1;
      int          stalls = 0;
      int          wr_idx = 0;
      int          stall_left = stall_len;
      bit          prev_stall = 1'b0;
      logic [18:0] prev_addr = '0;
      logic        w;
      int          tries = 0;

      @(negedge clk);
      while (!cmd_ready && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready-timeout: ready=%b required 1", name, cmd_ready);
         return;
      end
      x0 = 10'(cx); y0 = 10'(cy); width = 10'(cw); height = 10'(ch); color = cc;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      if (spam) begin
         x0 = 10'(cx + 7); y0 = 10'(cy + 3); width = 10'(cw + 2); height = 10'(ch + 1); color = ~cc;
      end else begin
         cmd_valid = 1'b0;
      end
      build_model(cx, cy, cw, ch);
      got_q.delete();
      waitreq = 1'b0;

      for (int j = 1; j < 5000; j++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (busy !== ~cmd_ready) begin
            n_fail++;
            $display("FAIL %s busy-vs-ready: busy=%b ready=%b", name, busy, cmd_ready);
         end
         if (prev_stall) begin
            n_checks++;
            if (vwrite !== 1'b1 || vaddr !== prev_addr || vdata !== cc) begin
               n_fail++;
               $display("FAIL %s stall-hold: write=%b addr=%0d data=%h required 1/%0d/%h",
                        name, vwrite, vaddr, vdata, prev_addr, cc);
            end
         end
         if (done === 1'b1) begin
            done_j = j;
            break;
         end
         if (vwrite === 1'b1) begin
            if (wr_idx == stall_idx && stall_left > 0) begin
               w = 1'b1;
               stall_left--;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
               w = 1'b1;
            end else begin
               w = 1'b0;
            end
            waitreq = w;
            if (!w) begin
               got_q.push_back(int'(vaddr));
               wr_idx++;
               n_checks++;
               if (vdata !== cc) begin
                  n_fail++;
                  $display("FAIL %s write-data: got %h required %h", name, vdata, cc);
               end
            end else begin
               stalls++;
            end
            prev_stall = w;
            prev_addr  = vaddr;
         end else begin
            waitreq    = 1'($urandom_range(0, 1));
            prev_stall = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      waitreq   = 1'b0;

      n_checks++;
      if (done_j < 0) begin
         n_fail++;
         $display("FAIL %s done-timeout: no done pulse seen, required one", name);
         return;
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write-count: got %0d required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] != exp_q[i]) begin
            n_fail++;
            $display("FAIL %s addr[%0d]: got %0d required %0d", name, i, got_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (done_j != 1 + exp_q.size() + stalls) begin
         n_fail++;
         $display("FAIL %s done-latency: got N+%0d required N+%0d", name, done_j + 1,
                  2 + exp_q.size() + stalls);
      end
      n_checks++;
      if (cmd_ready !== 1'b1 || vwrite !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done-cycle: ready=%b write=%b required 1/0", name, cmd_ready, vwrite);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done-pulse-width: done=%b ready=%b required 0/1", name, done, cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; waitreq = 1'b0;
      x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || vwrite !== 1'b0 ||
          vaddr !== 19'd0 || vdata !== 8'd0) begin
         n_fail++;
         $display("FAIL reset-values: ready=%b busy=%b done=%b write=%b addr=%0d data=%h required 1/0/0/0/0/00",
                  cmd_ready, busy, done, vwrite, vaddr, vdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      run_cmd("basic", 10, 2, 3, 2, 8'hA5, 0, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_cmd("stall", 10, 2, 3, 2, 8'hA5, 0, 1, 3, 1'b0);
   endtask

   task automatic test_empty();
      run_cmd("empty-w", 5, 5, 0, 4, 8'h3C, 0, -1, 0, 1'b0);
      run_cmd("empty-h", 5, 5, 7, 0, 8'h3C, 0, -1, 0, 1'b0);
   endtask

   task automatic test_clip_edge();
      run_cmd("row-edge", 638, 0, 4, 1, 8'h11, 0, -1, 0, 1'b0);
      run_cmd("frame-corner", 636, 478, 8, 5, 8'h22, 0, -1, 0, 1'b0);
      run_cmd("off-frame", 700, 10, 3, 2, 8'h33, 0, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      x0 = 10'd0; y0 = 10'd5; width = 10'd20; height = 10'd3; color = 8'h5A;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (vwrite !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset-mid-write: write=%b ready=%b busy=%b done=%b required 0/1/0/0",
                  vwrite, cmd_ready, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (done !== 1'b0 || vwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset-abandon: done=%b write=%b required 0/0", done, vwrite);
         end
      end
      run_cmd("after-reset", 10, 2, 3, 2, 8'hA5, 0, -1, 0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      run_cmd("busy-ignore", 20, 7, 4, 3, 8'hC3, 0, -1, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_cmd("b2b-a", 100, 100, 5, 2, 8'h01, 20, -1, 0, 1'b0);
      run_cmd("b2b-b", 0, 0, 1, 1, 8'hFE, 0, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      int rx, ry, rw, rh, sp;
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            rx = 630 + $urandom_range(0, 15);
            ry = 474 + $urandom_range(0, 10);
         end else begin
            rx = $urandom_range(0, 1023);
            ry = $urandom_range(0, 1023);
         end
         rw = $urandom_range(0, 12);
         rh = $urandom_range(0, 6);
         sp = $urandom_range(0, 40);
         run_cmd("random", rx, ry, rw, rh, 8'($urandom), sp, -1, 0, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_clip_edge();
      test_reset_mid_write();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
